// File: rtl/dual_stack_pkg.sv
// Shared op/status codes, host state encoding and default sizing for the dual-stack subsystem.
package dual_stack_pkg;

  localparam int unsigned DEFAULT_WORDS = 24;
  localparam int unsigned DATA_W        = 8;
  localparam int unsigned CNT_W         = 5;

  typedef enum logic [1:0] {
    OP_PUSH = 2'b00,
    OP_POP  = 2'b01,
    OP_MOVE = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK    = 2'b00,
    ST_FULL  = 2'b01,
    ST_EMPTY = 2'b10,
    ST_BADOP = 2'b11
  } status_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_POP,
    S_WAIT,
    S_MPUSH,
    S_SETTLE,
    S_RESP
  } state_e;

endpackage

// File: rtl/dual_stack.sv
// Two independent LIFO stacks sharing one strobe/data port; read data is registered on pop.
module dual_stack
  import dual_stack_pkg::*;
#(
  parameter int unsigned WORDS = DEFAULT_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stack_select,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              s0_empty,
  output logic              s0_full,
  output logic              s1_empty,
  output logic              s1_full
);

  localparam int unsigned PTR_W  = $clog2(WORDS + 1);
  localparam int unsigned ADDR_W = $clog2(WORDS);

  logic [DATA_W-1:0] mem0 [WORDS];
  logic [DATA_W-1:0] mem1 [WORDS];
  logic [PTR_W-1:0]  cnt0, cnt1, cnt_sel_c;
  logic [ADDR_W-1:0] wr_addr_c, rd_addr_c;
  logic              do_push_c, do_pop_c;

  assign s0_empty  = (cnt0 == '0);
  assign s1_empty  = (cnt1 == '0);
  assign s0_full   = (cnt0 == PTR_W'(WORDS));
  assign s1_full   = (cnt1 == PTR_W'(WORDS));
  assign cnt_sel_c = stack_select ? cnt1 : cnt0;
  assign wr_addr_c = ADDR_W'(cnt_sel_c);
  assign rd_addr_c = ADDR_W'(cnt_sel_c - PTR_W'(1));
  // Overflowing pushes and underflowing pops are silently dropped.
  assign do_push_c = push && !(stack_select ? s1_full : s0_full);
  assign do_pop_c  = pop && !push && !(stack_select ? s1_empty : s0_empty);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else if (do_push_c) begin
      if (stack_select) cnt1 <= cnt1 + PTR_W'(1);
      else              cnt0 <= cnt0 + PTR_W'(1);
    end else if (do_pop_c) begin
      if (stack_select) cnt1 <= cnt1 - PTR_W'(1);
      else              cnt0 <= cnt0 - PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push_c) begin
      if (stack_select) mem1[wr_addr_c] <= data_in;
      else              mem0[wr_addr_c] <= data_in;
    end
    if (do_pop_c) data_out <= stack_select ? mem1[rd_addr_c] : mem0[rd_addr_c];
  end

endmodule

// File: rtl/dual_stack_host.sv
// Command-driven initiator for the dual stack: push/pop/move commands in, byte + status responses out.
module dual_stack_host
  import dual_stack_pkg::*;
#(
  parameter int unsigned WORDS = DEFAULT_WORDS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic              cmd_sel,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_status,
  input  logic              s0_empty,
  input  logic              s0_full,
  input  logic              s1_empty,
  input  logic              s1_full,
  output logic              stack_select,
  output logic              push,
  output logic              pop,
  output logic [DATA_W-1:0] stack_wdata,
  input  logic [DATA_W-1:0] stack_rdata
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WORDS);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic              sel_q, sel_d;
  logic [DATA_W-1:0] byte_q, byte_d;
  logic [CNT_W-1:0]  count_q, count_d, moved_q, moved_d, req_cnt_c;
  logic              rsp_valid_d, cmd_ready_d, push_d, pop_d, select_d;
  logic [DATA_W-1:0] rsp_data_d, wdata_d;
  status_e           rsp_status_d;
  logic              cmd_full_c, cmd_empty_c, src_empty_c, dst_full_c;

  assign cmd_full_c  = cmd_sel ? s1_full  : s0_full;
  assign cmd_empty_c = cmd_sel ? s1_empty : s0_empty;
  assign src_empty_c = sel_q   ? s1_empty : s0_empty;
  assign dst_full_c  = sel_q   ? s0_full  : s1_full;
  assign req_cnt_c   = cmd_data[CNT_W-1:0];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    sel_d        = sel_q;
    byte_d       = byte_q;
    count_d      = count_q;
    moved_d      = moved_q;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = rsp_data;
    rsp_status_d = status_e'(rsp_status);
    select_d     = stack_select;
    wdata_d      = stack_wdata;
    push_d       = 1'b0;
    pop_d        = 1'b0;
    cmd_ready_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d         = op_e'(cmd_op);
          sel_d        = cmd_sel;
          byte_d       = cmd_data;
          moved_d      = '0;
          count_d      = (req_cnt_c > MAX_CNT) ? MAX_CNT : req_cnt_c;
          rsp_data_d   = '0;
          rsp_status_d = ST_OK;
          unique case (op_d)
            OP_PUSH: begin
              if (cmd_full_c) begin
                rsp_status_d = ST_FULL;
                state_d      = S_RESP;
              end else begin
                state_d = S_PUSH;
              end
            end
            OP_POP: begin
              if (cmd_empty_c) begin
                rsp_status_d = ST_EMPTY;
                state_d      = S_RESP;
              end else begin
                state_d = S_POP;
              end
            end
            OP_MOVE: state_d = (count_d == '0) ? S_RESP : S_POP;
            default: begin
              rsp_status_d = ST_BADOP;
              state_d      = S_RESP;
            end
          endcase
        end
      end
      S_PUSH: state_d = S_RESP;
      S_POP:  state_d = S_WAIT;
      S_WAIT: begin
        byte_d = stack_rdata;
        if (op_q == OP_POP) begin
          rsp_data_d = stack_rdata;
          state_d    = S_RESP;
        end else begin
          state_d = S_MPUSH;
        end
      end
      S_MPUSH: begin
        moved_d = moved_q + CNT_W'(1);
        state_d = S_SETTLE;
      end
      S_SETTLE: begin
        // Empty source wins over full destination when both stop the move.
        rsp_data_d = DATA_W'(moved_q);
        if (moved_q == count_q) begin
          rsp_status_d = ST_OK;
          state_d      = S_RESP;
        end else if (src_empty_c) begin
          rsp_status_d = ST_EMPTY;
          state_d      = S_RESP;
        end else if (dst_full_c) begin
          rsp_status_d = ST_FULL;
          state_d      = S_RESP;
        end else begin
          state_d = S_POP;
        end
      end
      S_RESP: begin
        if (rsp_valid && rsp_ready) state_d = S_IDLE;
        else                        rsp_valid_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they align with the state they belong to.
    push_d      = (state_d == S_PUSH) || (state_d == S_MPUSH);
    pop_d       = (state_d == S_POP);
    cmd_ready_d = (state_d == S_IDLE);
    if (state_d == S_PUSH) begin
      select_d = sel_d;
      wdata_d  = byte_d;
    end else if (state_d == S_MPUSH) begin
      select_d = ~sel_d;
      wdata_d  = byte_d;
    end else if (state_d == S_POP) begin
      select_d = sel_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op_q         <= OP_PUSH;
      sel_q        <= 1'b0;
      byte_q       <= '0;
      count_q      <= '0;
      moved_q      <= '0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_status   <= ST_OK;
      push         <= 1'b0;
      pop          <= 1'b0;
      stack_select <= 1'b0;
      stack_wdata  <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      sel_q        <= sel_d;
      byte_q       <= byte_d;
      count_q      <= count_d;
      moved_q      <= moved_d;
      cmd_ready    <= cmd_ready_d;
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= rsp_data_d;
      rsp_status   <= rsp_status_d;
      push         <= push_d;
      pop          <= pop_d;
      stack_select <= select_d;
      stack_wdata  <= wdata_d;
    end
  end

endmodule

// File: tb/tb_dual_stack_host.sv
// Directed bench for dual_stack_host driving a dual_stack responder.
module tb_dual_stack_host;
  import dual_stack_pkg::*;

  localparam int unsigned WORDS = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stk_rst = 1'b1;
  logic       cmd_valid, cmd_ready, cmd_sel, rsp_valid, rsp_ready;
  logic [1:0] cmd_op, rsp_status;
  logic [7:0] cmd_data, rsp_data, stack_wdata, stack_rdata;
  logic       s0_empty, s0_full, s1_empty, s1_full;
  logic       stack_select, push, pop;

  int n_cmp = 0, n_fail = 0;
  int n_push = 0, n_pop = 0, n_both = 0, n_rsp = 0;

  dual_stack_host #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_sel(cmd_sel), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_status(rsp_status),
    .s0_empty(s0_empty), .s0_full(s0_full), .s1_empty(s1_empty), .s1_full(s1_full),
    .stack_select(stack_select), .push(push), .pop(pop),
    .stack_wdata(stack_wdata), .stack_rdata(stack_rdata)
  );

  dual_stack #(.WORDS(WORDS)) stk (
    .clk(clk), .rst(stk_rst),
    .stack_select(stack_select), .push(push), .pop(pop),
    .data_in(stack_wdata), .data_out(stack_rdata),
    .s0_empty(s0_empty), .s0_full(s0_full), .s1_empty(s1_empty), .s1_full(s1_full)
  );

  always #5 clk = ~clk;

  // Strobe/response activity as seen by the stack at each sampling edge.
  always @(posedge clk) begin
    if (push) n_push++;
    if (pop) n_pop++;
    if (push && pop) n_both++;
    if (rsp_valid) n_rsp++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic sel, input logic [7:0] data);
    int n = 0;
    cmd_op = op; cmd_sel = sel; cmd_data = data; cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!rsp_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("rsp_valid_wait", 32'(rsp_valid), 32'd1);
  endtask

  task automatic take_rsp(output logic [7:0] d, output logic [1:0] st);
    d = rsp_data;
    st = rsp_status;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic run(input logic [1:0] op, input logic sel, input logic [7:0] data,
                     output logic [7:0] d, output logic [1:0] st, output int lat);
    issue(op, sel, data);
    wait_rsp(lat);
    take_rsp(d, st);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [1:0] st;
    int lat, p0, ok_cnt;
    cmd_valid = 1'b0; rsp_ready = 1'b0; cmd_op = 2'b00; cmd_sel = 1'b0; cmd_data = 8'h00;

    // Reset values
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'h00);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_push", 32'(push), 32'd0);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_select", 32'(stack_select), 32'd0);
    check("rst_wdata", 32'(stack_wdata), 32'h00);
    tick(); tick();
    rst = 1'b0; stk_rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Push then pop 0xA5 on s0
    p0 = n_push;
    run(OP_PUSH, 1'b0, 8'hA5, d, st, lat);
    check("push_status", 32'(st), 32'(ST_OK));
    check("push_data", 32'(d), 32'h00);
    check("push_latency", lat, 2);
    check("push_strobes", n_push - p0, 1);
    check("push_s0_empty", 32'(s0_empty), 32'd0);
    p0 = n_pop;
    run(OP_POP, 1'b0, 8'h00, d, st, lat);
    check("pop_status", 32'(st), 32'(ST_OK));
    check("pop_data", 32'(d), 32'hA5);
    check("pop_latency", lat, 3);
    check("pop_strobes", n_pop - p0, 1);
    check("pop_s0_empty", 32'(s0_empty), 32'd1);

    // Error responses
    p0 = n_pop;
    run(OP_POP, 1'b1, 8'h00, d, st, lat);
    check("empty_status", 32'(st), 32'(ST_EMPTY));
    check("empty_data", 32'(d), 32'h00);
    check("empty_latency", lat, 1);
    check("empty_no_pop", n_pop - p0, 0);
    run(OP_RSVD, 1'b0, 8'h33, d, st, lat);
    check("badop_status", 32'(st), 32'(ST_BADOP));
    check("badop_latency", lat, 1);

    // Fill s0, overflow push, drain
    ok_cnt = 0;
    for (int i = 0; i < 24; i++) begin
      run(OP_PUSH, 1'b0, 8'(i), d, st, lat);
      if (st == 2'(ST_OK)) ok_cnt++;
    end
    check("fill_ok_count", ok_cnt, 24);
    check("fill_s0_full", 32'(s0_full), 32'd1);
    p0 = n_push;
    run(OP_PUSH, 1'b0, 8'h55, d, st, lat);
    check("full_status", 32'(st), 32'(ST_FULL));
    check("full_latency", lat, 1);
    check("full_no_push", n_push - p0, 0);
    for (int i = 0; i < 24; i++) begin
      run(OP_POP, 1'b0, 8'h00, d, st, lat);
      check("drain_data", 32'(d), 32'(23 - i));
    end
    check("drain_s0_empty", 32'(s0_empty), 32'd1);

    // Move stopped early by empty source
    run(OP_PUSH, 1'b0, 8'd1, d, st, lat);
    run(OP_PUSH, 1'b0, 8'd2, d, st, lat);
    run(OP_PUSH, 1'b0, 8'd3, d, st, lat);
    run(OP_MOVE, 1'b0, 8'd5, d, st, lat);
    check("move5_status", 32'(st), 32'(ST_EMPTY));
    check("move5_data", 32'(d), 32'd3);
    check("move5_latency", lat, 13);
    check("move5_s0_empty", 32'(s0_empty), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      run(OP_POP, 1'b1, 8'h00, d, st, lat);
      check("move5_s1_pop", 32'(d), 32'(i));
    end
    check("move5_s1_empty", 32'(s1_empty), 32'd1);

    // Complete move s1->s0; upper data bits ignored for the count
    run(OP_PUSH, 1'b1, 8'h07, d, st, lat);
    run(OP_PUSH, 1'b1, 8'h08, d, st, lat);
    run(OP_MOVE, 1'b1, 8'hE2, d, st, lat);
    check("move2_status", 32'(st), 32'(ST_OK));
    check("move2_data", 32'(d), 32'd2);
    check("move2_latency", lat, 9);
    run(OP_POP, 1'b0, 8'h00, d, st, lat);
    check("move2_pop_a", 32'(d), 32'h07);
    run(OP_POP, 1'b0, 8'h00, d, st, lat);
    check("move2_pop_b", 32'(d), 32'h08);
    p0 = n_push + n_pop;
    run(OP_MOVE, 1'b0, 8'h00, d, st, lat);
    check("move0_status", 32'(st), 32'(ST_OK));
    check("move0_data", 32'(d), 32'h00);
    check("move0_latency", lat, 1);
    check("move0_no_strobes", n_push + n_pop - p0, 0);

    // Back-pressure on the response channel
    issue(OP_PUSH, 1'b0, 8'h11);
    wait_rsp(lat);
    p0 = n_push + n_pop;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
      check("hold_rsp_data", 32'(rsp_data), 32'h00);
      check("hold_rsp_status", 32'(rsp_status), 32'(ST_OK));
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    check("hold_no_strobes", n_push + n_pop - p0, 0);
    take_rsp(d, st);
    check("hold_cmd_ready_after", 32'(cmd_ready), 32'd1);
    run(OP_POP, 1'b0, 8'h00, d, st, lat);
    check("hold_pop", 32'(d), 32'h11);

    // Reset in the middle of a move's first MPUSH
    for (int i = 1; i <= 4; i++) run(OP_PUSH, 1'b0, 8'(8'h20 + i), d, st, lat);
    issue(OP_MOVE, 1'b0, 8'd4);
    tick(); tick();
    check("mpush_push", 32'(push), 32'd1);
    check("mpush_select", 32'(stack_select), 32'd1);
    check("mpush_wdata", 32'(stack_wdata), 32'h24);
    p0 = n_rsp;
    #2 rst = 1'b1;
    #1;
    check("rst_drop_push", 32'(push), 32'd0);
    check("rst_drop_pop", 32'(pop), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (5) tick();
    check("rst_mid_no_rsp", n_rsp - p0, 0);
    check("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_mid_s0_empty", 32'(s0_empty), 32'd0);
    check("rst_mid_s1_empty", 32'(s1_empty), 32'd1);
    run(OP_POP, 1'b0, 8'h00, d, st, lat);
    check("rst_mid_pop", 32'(d), 32'h23);

    check("push_pop_overlap", n_both, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dual_stack_host.md
# dual_stack_host

Command-driven initiator for the dual-stack storage block: accepts push, pop and move commands over a valid/ready command channel, checks the per-stack full/empty flags, and drives the single-cycle `stack_select`/`push`/`pop` strobes. It returns a data byte and a status code over a valid/ready response channel. It sits between the chip's command decoder and the dual stack.

## Interface
- `WORDS`, default 24: capacity of each stack; move counts are clamped to this.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: host idle; command accepted on an edge where valid&&ready.
- `cmd_op` in 2: 00 push, 01 pop, 10 move, 11 reserved.
- `cmd_sel` in 1: target stack (push/pop); source stack (move); destination is `~cmd_sel`.
- `cmd_data` in 8: push byte; for move, bits [4:0] are the item count.
- `rsp_valid` out 1: response held until accepted.
- `rsp_ready` in 1: response consumer ready.
- `rsp_data` out 8: popped byte (pop), items moved (move), 0 otherwise.
- `rsp_status` out 2: 00 ok, 01 full, 10 empty, 11 bad op.
- `s0_empty`, `s0_full`, `s1_empty`, `s1_full` in 1 each: stack flags.
- `stack_select` out 1, `push` out 1, `pop` out 1: stack strobes, all registered.
- `stack_wdata` out 8: to stack `data_in`.
- `stack_rdata` in 8: from stack `data_out`.

## Operation
- Stack contract: strobes sampled at the rising edge. Flags are valid the cycle after a strobe. `stack_rdata` is valid the cycle after a pop strobe.
- States: IDLE, PUSH, POP, WAIT, MPUSH, SETTLE, RESP.
- IDLE: `cmd_ready`=1. On accept, latch op, sel, data and evaluate flags of the current cycle.
  - push to full stack: status 01 → RESP.
  - pop from empty stack: status 10 → RESP.
  - op 11: status 11 → RESP.
  - push ok → PUSH.
  - pop ok → POP.
  - move: count = min(`cmd_data[4:0]`, WORDS). Count 0 → RESP with status 00, data 0. Otherwise → POP with moved=0.
- PUSH: `push`=1, `stack_select`=sel, `stack_wdata`=byte → RESP with status 00.
- POP: `pop`=1, `stack_select`=src → WAIT.
- WAIT: capture `stack_rdata`.
  - pop op → RESP with data = byte.
  - move → MPUSH.
- MPUSH: `push`=1, `stack_select`=~src, `stack_wdata`=captured byte; moved+1 → SETTLE.
- SETTLE: decide on the move's next step.
  - moved==count → RESP with status 00.
  - src empty → RESP with status 10.
  - dst full → RESP with status 01.
  - otherwise → POP.
  - Empty is checked before full. `rsp_data` = moved.
- RESP: `rsp_valid`=1; `rsp_data`/`rsp_status` stable. On `rsp_ready` → IDLE.
- A move reverses element order on the destination stack (LIFO to LIFO).
- Outside PUSH/POP/MPUSH, `push`=`pop`=0. `push` and `pop` are never high together.
- Reset mid-operation: state → IDLE and all strobes drop immediately (async). Partially moved data remains in the stacks; no response is issued.

## Timing
- Reset values: `cmd_ready` 0 while `rst` high, then 1; `rsp_valid` 0; `rsp_data` 0; `rsp_status` 00; `push` 0; `pop` 0; `stack_select` 0; `stack_wdata` 0.
- Accept edge = E0. Timing per command type:
  - Push: strobe during cycle after E0; `rsp_valid` from E2.
  - Pop: strobe after E0; capture at E2; `rsp_valid` from E3.
  - Error: `rsp_valid` from E1; no strobes.
  - Move: 4 cycles per item (POP, WAIT, MPUSH, SETTLE); `rsp_valid` at E(4n+1) when n items are moved with no early stop.
- Throughput: one command in flight. `cmd_ready`=0 from E0 until the RESP handshake edge. The next command may be accepted in the cycle after `rsp_valid` drops.
- Flags are sampled only in IDLE and SETTLE, each at least one cycle after the last strobe, so they are always settled.

## Structure
- Package `dual_stack_pkg` holds:
  - op codes `OP_PUSH`, `OP_POP`, `OP_MOVE`, `OP_RSVD`;
  - status codes `ST_OK`, `ST_FULL`, `ST_EMPTY`, `ST_BADOP`;
  - the state enum;
  - default `WORDS`=24.
- Single flat module with no sub-module. Count and moved registers are 5 bits wide.
- The bench instantiates `dual_stack` as the responder.

## Test plan
- Reset, then push 0xA5 to s0 and pop from s0 → responses 00/0x00 then 00/0xA5. `s0_empty` is 1 afterwards. Push response arrives at E2, pop response at E3.
- Pop from empty s1 → status 10, data 0, `rsp_valid` at E1, no `pop` strobe. Op 11 → status 11.
- Push 0..23 to s0, then push 0x55 to s0 → 24 ok responses, then status 01. Stack contents are unchanged.
- Push 1,2,3 to s0, then move count 5 from s0 → status 10, data 3. Popping s1 returns 1, 2, 3.
- Hold `rsp_ready` low for 10 cycles → `rsp_valid`, data and status are stable, `cmd_ready` stays 0, and no strobes occur.
- Assert `rst` during MPUSH of a 4-item move → strobes drop the same cycle, `cmd_ready` is 1 after release, and no response is issued.
